// File: rtl/exe_pkg.sv
// Shared issue-stage parameters plus the age and wakeup helpers used by the
// scheduler and its oldest-ready picker.
package exe_pkg;

  localparam int ROBWIDTH = 6;
  localparam int DEPTH    = 4;
  localparam int TAGW     = 6;
  localparam int CNTW     = 3;

  // Distance from the ROB head; modular subtraction keeps it correct across pointer wrap.
  function automatic logic [ROBWIDTH-1:0] rob_age(input logic [ROBWIDTH-1:0] ptr,
                                                  input logic [ROBWIDTH-1:0] head);
    return ptr - head;
  endfunction

  function automatic logic tag_hit(input logic [TAGW-1:0] tag,
                                   input logic [TAGW-1:0] alu_tag,
                                   input logic            alu_vld,
                                   input logic [TAGW-1:0] ls_tag,
                                   input logic            ls_vld);
    return (tag == 6'd0) || (alu_vld && (tag == alu_tag)) || (ls_vld && (tag == ls_tag));
  endfunction

endpackage

// File: rtl/exe_issue_sched_if.sv
// Dispatch, result-broadcast and issue-payload bundle of the issue scheduler.
interface exe_issue_sched_if #(parameter int ROBWIDTH = exe_pkg::ROBWIDTH);

  logic                disp_valid;
  logic                disp_ready;
  logic [31:0]         disp_Instr;
  logic [ROBWIDTH-1:0] disp_ROBPointer;
  logic [5:0]          disp_regA;
  logic [5:0]          disp_regB;
  logic                disp_rdyA;
  logic                disp_rdyB;
  logic [5:0]          fwd_reg_1_COM;
  logic                fwd_data_1_COM_flag;
  logic [5:0]          LS_fwd_reg_COM;
  logic                LS_fwd_data_COM_flag;
  logic                Issue_valid_OUT;
  logic [31:0]         Instr1_OUT;
  logic [ROBWIDTH-1:0] ROBPointer_OUT;
  logic [5:0]          readRegisterA1_OUT;
  logic [5:0]          readRegisterB1_OUT;
  logic [2:0]          Count_OUT;

  modport slave (
    input  disp_valid, disp_Instr, disp_ROBPointer, disp_regA, disp_regB, disp_rdyA, disp_rdyB,
           fwd_reg_1_COM, fwd_data_1_COM_flag, LS_fwd_reg_COM, LS_fwd_data_COM_flag,
    output disp_ready, Issue_valid_OUT, Instr1_OUT, ROBPointer_OUT,
           readRegisterA1_OUT, readRegisterB1_OUT, Count_OUT
  );

  modport master (
    output disp_valid, disp_Instr, disp_ROBPointer, disp_regA, disp_regB, disp_rdyA, disp_rdyB,
           fwd_reg_1_COM, fwd_data_1_COM_flag, LS_fwd_reg_COM, LS_fwd_data_COM_flag,
    input  disp_ready, Issue_valid_OUT, Instr1_OUT, ROBPointer_OUT,
           readRegisterA1_OUT, readRegisterB1_OUT, Count_OUT
  );

endinterface

// File: rtl/exe_issue_sched_age_select.sv
// Combinational DEPTH-way picker: index of the eligible entry closest to the ROB head.
module age_select #(
  parameter int ROBWIDTH = exe_pkg::ROBWIDTH,
  parameter int DEPTH    = exe_pkg::DEPTH,
  parameter int IDXW     = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic [DEPTH-1:0]    elig_i,
  input  logic [ROBWIDTH-1:0] rob_i [DEPTH],
  input  logic [ROBWIDTH-1:0] head_i,
  output logic [IDXW-1:0]     idx_o,
  output logic                any_o
);

  logic [ROBWIDTH-1:0] best_age_s;

  // Linear minimum scan; strict compare keeps the lower index on a tie.
  always_comb begin
    idx_o      = '0;
    any_o      = 1'b0;
    best_age_s = '1;
    for (int i = 0; i < DEPTH; i++) begin
      if (elig_i[i] && (!any_o || (exe_pkg::rob_age(rob_i[i], head_i) < best_age_s))) begin
        any_o      = 1'b1;
        idx_o      = IDXW'(i);
        best_age_s = exe_pkg::rob_age(rob_i[i], head_i);
      end
    end
  end

endmodule

// File: rtl/exe_issue_sched.sv
// Out-of-order issue queue: tag wakeup from two result buses, oldest-ready select
// into a single registered issue slot, with stall and squash.
module exe_issue_sched #(
  parameter int ROBWIDTH = exe_pkg::ROBWIDTH,
  parameter int DEPTH    = exe_pkg::DEPTH
) (
  input  logic                CLK,
  input  logic                RESET,
  input  logic                FREEZE,
  input  logic                FLUSH,
  input  logic [ROBWIDTH-1:0] ROB_head,
  exe_issue_sched_if.slave    bus
);

  localparam int IDXW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DEPTH-1:0]    valid_q, valid_d, rdy_a_q, rdy_a_d, rdy_b_q, rdy_b_d;
  logic [31:0]         instr_q [DEPTH];
  logic [31:0]         instr_d [DEPTH];
  logic [ROBWIDTH-1:0] rob_q   [DEPTH];
  logic [ROBWIDTH-1:0] rob_d   [DEPTH];
  logic [5:0]          tag_a_q [DEPTH];
  logic [5:0]          tag_a_d [DEPTH];
  logic [5:0]          tag_b_q [DEPTH];
  logic [5:0]          tag_b_d [DEPTH];

  logic                iss_valid_q, iss_valid_d;
  logic [31:0]         iss_instr_q, iss_instr_d;
  logic [ROBWIDTH-1:0] iss_rob_q, iss_rob_d;
  logic [5:0]          iss_ra_q, iss_ra_d, iss_rb_q, iss_rb_d;
  logic [2:0]          count_q, count_d;

  logic [DEPTH-1:0]    elig_s;
  logic [IDXW-1:0]     sel_idx_s, free_idx_s;
  logic                sel_any_s, disp_ready_s, disp_fire_s, issue_fire_s;

  // Readiness is taken from registered bits only, so a broadcast never wakes and issues in one cycle.
  assign elig_s       = valid_q & rdy_a_q & rdy_b_q;
  assign disp_ready_s = (32'(count_q) < DEPTH);

  age_select #(.ROBWIDTH(ROBWIDTH), .DEPTH(DEPTH), .IDXW(IDXW)) u_age_select (
    .elig_i (elig_s),
    .rob_i  (rob_q),
    .head_i (ROB_head),
    .idx_o  (sel_idx_s),
    .any_o  (sel_any_s)
  );

  // Lowest free slot, judged on pre-issue occupancy so a slot freed this cycle is not reused.
  always_comb begin
    free_idx_s = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (!valid_q[i]) begin
        free_idx_s = IDXW'(i);
      end
    end
  end

  // Next-state: wakeup, issue, dispatch, occupancy, then squash overriding all.
  always_comb begin
    valid_d      = valid_q;
    rdy_a_d      = rdy_a_q;
    rdy_b_d      = rdy_b_q;
    instr_d      = instr_q;
    rob_d        = rob_q;
    tag_a_d      = tag_a_q;
    tag_b_d      = tag_b_q;
    iss_valid_d  = iss_valid_q;
    iss_instr_d  = iss_instr_q;
    iss_rob_d    = iss_rob_q;
    iss_ra_d     = iss_ra_q;
    iss_rb_d     = iss_rb_q;
    disp_fire_s  = bus.disp_valid && disp_ready_s;
    issue_fire_s = !FREEZE && sel_any_s;

    for (int i = 0; i < DEPTH; i++) begin
      if (exe_pkg::tag_hit(tag_a_q[i], bus.fwd_reg_1_COM, bus.fwd_data_1_COM_flag,
                           bus.LS_fwd_reg_COM, bus.LS_fwd_data_COM_flag)) begin
        rdy_a_d[i] = 1'b1;
      end
      if (exe_pkg::tag_hit(tag_b_q[i], bus.fwd_reg_1_COM, bus.fwd_data_1_COM_flag,
                           bus.LS_fwd_reg_COM, bus.LS_fwd_data_COM_flag)) begin
        rdy_b_d[i] = 1'b1;
      end
    end

    if (issue_fire_s) begin
      valid_d[sel_idx_s] = 1'b0;
      iss_valid_d        = 1'b1;
      iss_instr_d        = instr_q[sel_idx_s];
      iss_rob_d          = rob_q[sel_idx_s];
      iss_ra_d           = tag_a_q[sel_idx_s];
      iss_rb_d           = tag_b_q[sel_idx_s];
    end else if (!FREEZE) begin
      iss_valid_d = 1'b0;
    end else begin
      iss_valid_d = iss_valid_q;
    end

    if (disp_fire_s) begin
      valid_d[free_idx_s] = 1'b1;
      instr_d[free_idx_s] = bus.disp_Instr;
      rob_d[free_idx_s]   = bus.disp_ROBPointer;
      tag_a_d[free_idx_s] = bus.disp_regA;
      tag_b_d[free_idx_s] = bus.disp_regB;
      rdy_a_d[free_idx_s] = bus.disp_rdyA ||
          exe_pkg::tag_hit(bus.disp_regA, bus.fwd_reg_1_COM, bus.fwd_data_1_COM_flag,
                           bus.LS_fwd_reg_COM, bus.LS_fwd_data_COM_flag);
      rdy_b_d[free_idx_s] = bus.disp_rdyB ||
          exe_pkg::tag_hit(bus.disp_regB, bus.fwd_reg_1_COM, bus.fwd_data_1_COM_flag,
                           bus.LS_fwd_reg_COM, bus.LS_fwd_data_COM_flag);
    end else begin
      valid_d[free_idx_s] = valid_d[free_idx_s];
    end

    count_d = count_q + 3'(disp_fire_s) - 3'(issue_fire_s);

    if (FLUSH) begin
      valid_d     = '0;
      iss_valid_d = 1'b0;
      count_d     = 3'd0;
    end else begin
      count_d = count_d;
    end
  end

  // State registers; reset leaves no entry, readiness or issue state behind.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      valid_q     <= '0;
      rdy_a_q     <= '0;
      rdy_b_q     <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        instr_q[i] <= '0;
        rob_q[i]   <= '0;
        tag_a_q[i] <= '0;
        tag_b_q[i] <= '0;
      end
      iss_valid_q <= 1'b0;
      iss_instr_q <= '0;
      iss_rob_q   <= '0;
      iss_ra_q    <= '0;
      iss_rb_q    <= '0;
      count_q     <= 3'd0;
    end else begin
      valid_q     <= valid_d;
      rdy_a_q     <= rdy_a_d;
      rdy_b_q     <= rdy_b_d;
      instr_q     <= instr_d;
      rob_q       <= rob_d;
      tag_a_q     <= tag_a_d;
      tag_b_q     <= tag_b_d;
      iss_valid_q <= iss_valid_d;
      iss_instr_q <= iss_instr_d;
      iss_rob_q   <= iss_rob_d;
      iss_ra_q    <= iss_ra_d;
      iss_rb_q    <= iss_rb_d;
      count_q     <= count_d;
    end
  end

  assign bus.disp_ready         = disp_ready_s;
  assign bus.Issue_valid_OUT    = iss_valid_q;
  assign bus.Instr1_OUT         = iss_instr_q;
  assign bus.ROBPointer_OUT     = iss_rob_q;
  assign bus.readRegisterA1_OUT = iss_ra_q;
  assign bus.readRegisterB1_OUT = iss_rb_q;
  assign bus.Count_OUT          = count_q;

endmodule

// File: tb/tb_exe_issue_sched.sv
// Directed scoreboard bench for exe_issue_sched: expected issues are queued at
// dispatch time and compared when the DUT presents a fresh issue.
module tb_exe_issue_sched;

  logic       CLK      = 1'b0;
  logic       RESET    = 1'b0;
  logic       FREEZE   = 1'b0;
  logic       FLUSH    = 1'b0;
  logic [5:0] ROB_head = 6'd0;

  always #5 CLK = ~CLK;

  exe_issue_sched_if #(.ROBWIDTH(6)) bus ();

  exe_issue_sched #(.ROBWIDTH(6), .DEPTH(4)) dut (
    .CLK      (CLK),
    .RESET    (RESET),
    .FREEZE   (FREEZE),
    .FLUSH    (FLUSH),
    .ROB_head (ROB_head),
    .bus      (bus)
  );

  typedef struct packed {
    logic [5:0]  rob;
    logic [31:0] instr;
    logic [5:0]  ra;
    logic [5:0]  rb;
  } exp_t;

  exp_t exp_q[$];
  int   n_pass  = 0;
  int   n_total = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  function automatic logic [31:0] mk_instr(input logic [5:0] rob);
    return {20'hC0DE5, 6'd0, rob};
  endfunction

  task automatic drive_disp(input logic [5:0] rob, input logic [5:0] ra, input logic rdya,
                            input logic [5:0] rb, input logic rdyb);
    bus.disp_valid      = 1'b1;
    bus.disp_Instr      = mk_instr(rob);
    bus.disp_ROBPointer = rob;
    bus.disp_regA       = ra;
    bus.disp_rdyA       = rdya;
    bus.disp_regB       = rb;
    bus.disp_rdyB       = rdyb;
  endtask

  task automatic expect_issue(input logic [5:0] rob, input logic [5:0] ra, input logic [5:0] rb);
    exp_t e;
    e.rob   = rob;
    e.instr = mk_instr(rob);
    e.ra    = ra;
    e.rb    = rb;
    exp_q.push_back(e);
  endtask

  // One clock edge; a valid issue after an unfrozen edge is a new issue and is scored.
  task automatic tick();
    logic frz;
    exp_t e;
    frz = FREEZE;
    @(posedge CLK);
    #1;
    if (bus.Issue_valid_OUT === 1'b1 && !frz) begin
      if (exp_q.size() == 0) begin
        chk("spurious_issue_rob", 32'(bus.ROBPointer_OUT), 32'hFFFF_FFFF);
      end else begin
        e = exp_q.pop_front();
        chk("issue_rob",   32'(bus.ROBPointer_OUT),     32'(e.rob));
        chk("issue_instr", bus.Instr1_OUT,              e.instr);
        chk("issue_regA",  32'(bus.readRegisterA1_OUT), 32'(e.ra));
        chk("issue_regB",  32'(bus.readRegisterB1_OUT), 32'(e.rb));
      end
    end
  endtask

  initial begin
    bus.disp_valid           = 1'b0;
    bus.disp_Instr           = 32'd0;
    bus.disp_ROBPointer      = 6'd0;
    bus.disp_regA            = 6'd0;
    bus.disp_regB            = 6'd0;
    bus.disp_rdyA            = 1'b0;
    bus.disp_rdyB            = 1'b0;
    bus.fwd_reg_1_COM        = 6'd0;
    bus.fwd_data_1_COM_flag  = 1'b0;
    bus.LS_fwd_reg_COM       = 6'd0;
    bus.LS_fwd_data_COM_flag = 1'b0;

    // Reset values
    repeat (2) @(posedge CLK);
    #1;
    chk("rst_issue_valid", 32'(bus.Issue_valid_OUT),    32'd0);
    chk("rst_count",       32'(bus.Count_OUT),          32'd0);
    chk("rst_disp_ready",  32'(bus.disp_ready),         32'd1);
    chk("rst_instr",       bus.Instr1_OUT,              32'd0);
    chk("rst_rob",         32'(bus.ROBPointer_OUT),     32'd0);
    chk("rst_regA",        32'(bus.readRegisterA1_OUT), 32'd0);
    chk("rst_regB",        32'(bus.readRegisterB1_OUT), 32'd0);
    RESET = 1'b1;
    tick();

    // Ready dispatch of ROB 5 issues one edge after it is written
    drive_disp(6'd5, 6'd3, 1'b1, 6'd4, 1'b1);
    expect_issue(6'd5, 6'd3, 6'd4);
    tick();
    bus.disp_valid = 1'b0;
    chk("basic_count_after_disp", 32'(bus.Count_OUT),       32'd1);
    chk("basic_no_issue_yet",     32'(bus.Issue_valid_OUT), 32'd0);
    tick();
    chk("basic_issued",           32'(bus.Issue_valid_OUT), 32'd1);
    chk("basic_count_after_iss",  32'(bus.Count_OUT),       32'd0);
    tick();
    chk("basic_idle_valid",       32'(bus.Issue_valid_OUT), 32'd0);
    chk("basic_payload_hold",     32'(bus.ROBPointer_OUT),  32'd5);

    // Wrap-around age: head 62, ROB 63 is older than ROB 1
    ROB_head = 6'd62;
    FREEZE   = 1'b1;
    drive_disp(6'd1, 6'd7, 1'b1, 6'd8, 1'b1);
    tick();
    drive_disp(6'd63, 6'd9, 1'b1, 6'd10, 1'b1);
    tick();
    bus.disp_valid = 1'b0;
    chk("wrap_count", 32'(bus.Count_OUT), 32'd2);
    expect_issue(6'd63, 6'd9, 6'd10);
    expect_issue(6'd1, 6'd7, 6'd8);
    FREEZE = 1'b0;
    tick();
    chk("wrap_first_is_63", 32'(bus.ROBPointer_OUT), 32'd63);
    tick();
    chk("wrap_second_is_1", 32'(bus.ROBPointer_OUT), 32'd1);
    tick();
    chk("wrap_drained", 32'(bus.Count_OUT), 32'd0);
    ROB_head = 6'd0;

    // ALU broadcast wakeup; tag 0 on B counts as ready
    drive_disp(6'd7, 6'd12, 1'b0, 6'd0, 1'b0);
    tick();
    bus.disp_valid = 1'b0;
    tick();
    tick();
    chk("alu_wait_no_issue", 32'(bus.Issue_valid_OUT), 32'd0);
    bus.fwd_reg_1_COM       = 6'd12;
    bus.fwd_data_1_COM_flag = 1'b1;
    expect_issue(6'd7, 6'd12, 6'd0);
    tick();
    bus.fwd_data_1_COM_flag = 1'b0;
    chk("alu_wake_edge1", 32'(bus.Issue_valid_OUT), 32'd0);
    tick();
    chk("alu_wake_edge2", 32'(bus.Issue_valid_OUT), 32'd1);

    // Load-bus broadcast wakeup
    drive_disp(6'd8, 6'd12, 1'b0, 6'd0, 1'b0);
    tick();
    bus.disp_valid = 1'b0;
    tick();
    chk("ls_wait_no_issue", 32'(bus.Issue_valid_OUT), 32'd0);
    bus.LS_fwd_reg_COM       = 6'd12;
    bus.LS_fwd_data_COM_flag = 1'b1;
    expect_issue(6'd8, 6'd12, 6'd0);
    tick();
    bus.LS_fwd_data_COM_flag = 1'b0;
    chk("ls_wake_edge1", 32'(bus.Issue_valid_OUT), 32'd0);
    tick();
    chk("ls_wake_edge2", 32'(bus.Issue_valid_OUT), 32'd1);

    // Broadcast coinciding with dispatch is captured at write
    drive_disp(6'd9, 6'd33, 1'b0, 6'd0, 1'b1);
    bus.fwd_reg_1_COM       = 6'd33;
    bus.fwd_data_1_COM_flag = 1'b1;
    expect_issue(6'd9, 6'd33, 6'd0);
    tick();
    bus.disp_valid          = 1'b0;
    bus.fwd_data_1_COM_flag = 1'b0;
    tick();
    chk("same_cycle_wake_issue", 32'(bus.Issue_valid_OUT), 32'd1);
    chk("same_cycle_wake_count", 32'(bus.Count_OUT),       32'd0);

    // Full queue: 5th dispatch refused, then drain in age order
    for (int i = 0; i < 4; i++) begin
      drive_disp(6'(10 + i), 6'(40 + i), 1'b0, 6'd0, 1'b1);
      tick();
    end
    chk("full_count",      32'(bus.Count_OUT),  32'd4);
    chk("full_disp_ready", 32'(bus.disp_ready), 32'd0);
    drive_disp(6'd20, 6'd1, 1'b1, 6'd2, 1'b1);
    tick();
    bus.disp_valid = 1'b0;
    chk("full_5th_ignored", 32'(bus.Count_OUT), 32'd4);
    for (int i = 0; i < 4; i++) begin
      expect_issue(6'(10 + i), 6'(40 + i), 6'd0);
    end
    bus.fwd_reg_1_COM        = 6'd40;
    bus.fwd_data_1_COM_flag  = 1'b1;
    bus.LS_fwd_reg_COM       = 6'd41;
    bus.LS_fwd_data_COM_flag = 1'b1;
    tick();
    bus.fwd_reg_1_COM  = 6'd42;
    bus.LS_fwd_reg_COM = 6'd43;
    tick();
    bus.fwd_data_1_COM_flag  = 1'b0;
    bus.LS_fwd_data_COM_flag = 1'b0;
    repeat (4) tick();
    chk("full_drained_count", 32'(bus.Count_OUT), 32'd0);
    chk("full_all_issued",    32'(exp_q.size()),  32'd0);

    // FREEZE holds the issue register and the queue
    drive_disp(6'd30, 6'd5, 1'b1, 6'd6, 1'b1);
    expect_issue(6'd30, 6'd5, 6'd6);
    tick();
    drive_disp(6'd31, 6'd7, 1'b1, 6'd8, 1'b1);
    expect_issue(6'd31, 6'd7, 6'd8);
    tick();
    bus.disp_valid = 1'b0;
    chk("frz_pre_rob", 32'(bus.ROBPointer_OUT), 32'd30);
    FREEZE = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("frz_hold_valid", 32'(bus.Issue_valid_OUT), 32'd1);
      chk("frz_hold_rob",   32'(bus.ROBPointer_OUT),  32'd30);
      chk("frz_hold_count", 32'(bus.Count_OUT),       32'd1);
    end
    FREEZE = 1'b0;
    tick();
    chk("frz_release_rob",   32'(bus.ROBPointer_OUT), 32'd31);
    chk("frz_release_count", 32'(bus.Count_OUT),      32'd0);

    // FLUSH beats dispatch, issue and FREEZE
    FREEZE = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive_disp(6'(40 + i), 6'd1, 1'b1, 6'd2, 1'b1);
      tick();
    end
    chk("flush_pre_count", 32'(bus.Count_OUT),       32'd3);
    chk("flush_pre_valid", 32'(bus.Issue_valid_OUT), 32'd1);
    drive_disp(6'd50, 6'd1, 1'b1, 6'd2, 1'b1);
    FLUSH = 1'b1;
    tick();
    FLUSH          = 1'b0;
    FREEZE         = 1'b0;
    bus.disp_valid = 1'b0;
    chk("flush_count", 32'(bus.Count_OUT),       32'd0);
    chk("flush_valid", 32'(bus.Issue_valid_OUT), 32'd0);
    repeat (3) tick();
    chk("flush_stays_empty", 32'(bus.Count_OUT), 32'd0);

    // Asynchronous reset mid-operation discards pending entries
    drive_disp(6'd50, 6'd44, 1'b0, 6'd0, 1'b1);
    tick();
    drive_disp(6'd51, 6'd45, 1'b0, 6'd0, 1'b1);
    tick();
    bus.disp_valid = 1'b0;
    chk("midrst_pre_count", 32'(bus.Count_OUT), 32'd2);
    #2;
    RESET = 1'b0;
    #1;
    chk("midrst_count",      32'(bus.Count_OUT),      32'd0);
    chk("midrst_disp_ready", 32'(bus.disp_ready),     32'd1);
    chk("midrst_rob",        32'(bus.ROBPointer_OUT), 32'd0);
    tick();
    RESET = 1'b1;
    bus.fwd_reg_1_COM        = 6'd44;
    bus.fwd_data_1_COM_flag  = 1'b1;
    bus.LS_fwd_reg_COM       = 6'd45;
    bus.LS_fwd_data_COM_flag = 1'b1;
    tick();
    bus.fwd_data_1_COM_flag  = 1'b0;
    bus.LS_fwd_data_COM_flag = 1'b0;
    repeat (3) tick();
    chk("midrst_no_issue", 32'(bus.Issue_valid_OUT), 32'd0);
    chk("midrst_count_0",  32'(bus.Count_OUT),       32'd0);
    chk("scoreboard_empty", 32'(exp_q.size()),       32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
